smul_sched: RTL and testbench

Sequencing controller for the signed integer multiplier datapath (`smul`). It accepts operand/weight pairs over a valid/ready handshake and drives the multiplier's `ce`, `sclr`, `select_precision` and `active_chain` controls. It tracks in-flight products through the fixed multiplier latency and stalls the pipeline under output backpressure. Precision changes are applied safely by draining in-flight work, then clearing the DSP pipeline. It sits between the DTPU operand fetch logic and one `smul` instance.

---
 rtl/smul_sched.sv | 153 +++++++++++++++
 tb/tb_smul_sched.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smul_sched.sv
// smul_sched: sequencing controller for one smul signed multiplier instance.
// Accepts operand/weight pairs over valid/ready, tracks in-flight products
// with a token shift register sized to the multiplier latency, stalls the
// DSP under output backpressure and applies precision changes by draining,
// clearing the DSP pipeline, then switching select_precision.
// Optional feature macro: SMUL_CHAIN_EN (enables INT64 via the DSP chain).
`timescale 1ns/1ps
module smul_sched #(
   parameter int MUL_LATENCY = 3,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       cfg_prec,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             cfg_done,
   output logic             cfg_err,
   input  logic [63:0]      in_data,
   input  logic [63:0]      in_weight,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [63:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      mul_a,
   output logic [63:0]      mul_w,
   input  logic [63:0]      mul_res,
   output logic             mul_ce,
   output logic             mul_sclr,
   output logic [3:0]       mul_prec,
   output logic [1:0]       mul_fp_en,
   output logic             mul_chain,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {RUN, DRAIN, CLEAR, APPLY} state_t;

`ifdef SMUL_CHAIN_EN
   localparam logic CHAIN_EN = 1'b1;
`else
   localparam logic CHAIN_EN = 1'b0;
`endif

   state_t                 state_q, state_d;
   logic [MUL_LATENCY-1:0] tok_q, tok_d;
   logic [1:0]             prec_q, prec_d;
   logic [1:0]             pend_q, pend_d;
   logic                   cfg_done_q, cfg_done_d;
   logic                   cfg_err_q, cfg_err_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   // Handshakes and stall: the DSP and tokens freeze only while a product
   // sits at the output unclaimed.
   assign out_valid = tok_q[MUL_LATENCY-1];
   assign mul_ce    = ~(out_valid & ~out_ready);
   assign in_ready  = (state_q == RUN) & mul_ce;
   assign cfg_ready = (state_q == RUN);
   assign cfg_done  = cfg_done_q;
   assign cfg_err   = cfg_err_q;
   assign busy      = (state_q != RUN) | (|tok_q);
   assign op_count  = cnt_q;

   // Datapath is a straight pass-through; only control is sequenced here.
   assign mul_a     = in_data;
   assign mul_w     = in_weight;
   assign out_data  = mul_res;
   assign mul_fp_en = 2'b00;
   assign mul_sclr  = (state_q == CLEAR);
   assign mul_prec  = 4'b0001 << prec_q;

`ifdef SMUL_CHAIN_EN
   assign mul_chain = (prec_q == 2'd3);
`else
   assign mul_chain = 1'b0;
`endif

   // Token shift register and delivered-product counter.
   always_comb begin
      tok_d = tok_q;
      cnt_d = cnt_q;
      if (mul_ce) begin
         tok_d[0] = in_valid & in_ready;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            tok_d[i] = tok_q[i-1];
         end
      end
      if (out_valid && out_ready) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Precision-change FSM: new precision becomes active one cycle after the
   // DSP clear, so select_precision never changes with products in flight.
   always_comb begin
      state_d    = state_q;
      prec_d     = prec_q;
      pend_d     = pend_q;
      cfg_done_d = 1'b0;
      cfg_err_d  = 1'b0;
      case (state_q)
         RUN: begin
            if (cfg_valid) begin
               if (cfg_prec == prec_q) begin
                  cfg_done_d = 1'b1;
               end else if (!CHAIN_EN && (cfg_prec == 2'd3)) begin
                  cfg_err_d = 1'b1;
               end else begin
                  pend_d  = cfg_prec;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (tok_q == '0) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            prec_d     = pend_q;
            cfg_done_d = 1'b1;
            state_d    = APPLY;
         end
         APPLY: begin
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // State registers; reset discards in-flight tokens but not DSP contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         tok_q      <= '0;
         prec_q     <= 2'd0;
         pend_q     <= 2'd0;
         cfg_done_q <= 1'b0;
         cfg_err_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         tok_q      <= tok_d;
         prec_q     <= prec_d;
         pend_q     <= pend_d;
         cfg_done_q <= cfg_done_d;
         cfg_err_q  <= cfg_err_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_smul_sched.sv
// Testbench for smul_sched with a behavioural smul model and a product
// scoreboard. Expectations for INT64 follow the SMUL_CHAIN_EN macro.
`timescale 1ns/1ps
module tb_smul_sched;
   localparam int L  = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    cfg_prec;
   logic          cfg_valid, cfg_ready, cfg_done, cfg_err;
   logic [63:0]   in_data, in_weight, out_data, mul_a, mul_w, mul_res;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic          mul_ce, mul_sclr, mul_chain, busy;
   logic [3:0]    mul_prec;
   logic [1:0]    mul_fp_en;
   logic [CW-1:0] op_count;

   int n_chk = 0;
   int n_fail = 0;
   logic [63:0] sb[$];
   logic [63:0] mon_exp;

   typedef struct {
      logic [63:0] a;
      logic [63:0] w;
      logic [63:0] exp;
   } vec_t;
   vec_t tbl[8];

   smul_sched #(.MUL_LATENCY(L), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .cfg_prec(cfg_prec), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
      .in_data(in_data), .in_weight(in_weight), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .mul_a(mul_a), .mul_w(mul_w), .mul_res(mul_res),
      .mul_ce(mul_ce), .mul_sclr(mul_sclr), .mul_prec(mul_prec),
      .mul_fp_en(mul_fp_en), .mul_chain(mul_chain), .busy(busy),
      .op_count(op_count)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_prod(input logic [63:0] a, input logic [63:0] w,
                                            input logic [3:0] p);
      logic signed [63:0] r;
      case (p)
         4'b0001: r = $signed(a[7:0])  * $signed(w[7:0]);
         4'b0010: r = $signed(a[15:0]) * $signed(w[15:0]);
         4'b0100: r = $signed(a[31:0]) * $signed(w[31:0]);
         4'b1000: r = $signed(a) * $signed(w);
         default: r = '0;
      endcase
      return r;
   endfunction

   // Behavioural smul: L ce-enabled stages, synchronous clear, no reset.
   logic [63:0] pipe [L];
   always @(posedge clk) begin
      if (mul_ce) begin
         if (mul_sclr) begin
            for (int i = 0; i < L; i++) pipe[i] <= '0;
         end else begin
            pipe[0] <= ref_prod(mul_a, mul_w, mul_prec);
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
         end
      end
   end
   assign mul_res = pipe[L-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every delivered product must match the oldest expected one.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got product %0h expected none", out_data);
         end else begin
            mon_exp = sb.pop_front();
            chk("sb_data", out_data, mon_exp);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] a, input logic [63:0] w, input logic [63:0] exp);
      bit ok;
      ok = 0;
      in_data = a;
      in_weight = w;
      in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(exp);
            ok = 1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 0, 1);
      tick;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain;
      bit ok;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) begin
            ok = 1;
            break;
         end
      end
      chk("drain_timeout", ok, 1);
      tick;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      in_valid = 1'b0;
      cfg_valid = 1'b0;
      out_ready = 1'b1;
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      tick;
      rst = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (cfg_done) begin
            cyc = k;
            break;
         end
      end
   endtask

   int lat, bad, rdy_bad, prec_bad, sclr_n, sclr_k, last_k, done_k, qsz, nv;
   logic [3:0]  prec_at_done;
   logic [63:0] hold, ra, rw;
   bit found;

   initial begin
      tbl[0] = '{64'h05, 64'hFD, 64'hFFFF_FFFF_FFFF_FFF1};
      tbl[1] = '{64'h7F, 64'h7F, 64'h0000_0000_0000_3F01};
      tbl[2] = '{64'h80, 64'h80, 64'h0000_0000_0000_4000};
      tbl[3] = '{64'h80, 64'h7F, 64'hFFFF_FFFF_FFFF_C080};
      tbl[4] = '{64'h1234_0003, 64'hFF00_0004, 64'h0000_0000_0000_000C};
      tbl[5] = '{64'h7FFF, 64'h7FFF, 64'h0000_0000_3FFF_0001};
      tbl[6] = '{64'h8000, 64'h0002, 64'hFFFF_FFFF_FFFF_0000};
      tbl[7] = '{64'hFFFF, 64'hFFFF, 64'h0000_0000_0000_0001};
      cfg_prec = 2'd0;
      in_data = '0;
      in_weight = '0;
      do_reset;

      // Reset values
      @(negedge clk);
      chk("rst_mul_prec", mul_prec, 4'b0001);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_mul_ce", mul_ce, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sclr", mul_sclr, 0);
      chk("rst_chain", mul_chain, 0);
      chk("rst_done_err", {cfg_done, cfg_err}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_fp_en", mul_fp_en, 0);
      tick;

      // Single INT8 op: latency and result
      send(tbl[0].a, tbl[0].w, tbl[0].exp);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      chk("latency", lat, L);
      chk("int8_byte", out_data[7:0], 8'hF1);
      tick;
      @(negedge clk);
      chk("op_count_1", op_count, 1);
      tick;

      // INT8 vectors back to back
      for (int i = 0; i < 5; i++) send(tbl[i].a, tbl[i].w, tbl[i].exp);
      wait_drain;
      chk("op_count_6", op_count, 6);

      // Backpressure: 4 inputs, out_ready low for 5 cycles from first out_valid
      do_reset;
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send(tbl[i].a, tbl[i].w, tbl[i].exp);
         end
         begin
            found = 0;
            for (int k = 0; k < 20; k++) begin
               @(negedge clk);
               if (out_valid) begin
                  found = 1;
                  break;
               end
            end
            chk("bp_first_valid", found, 1);
            hold = out_data;
            bad = 0;
            for (int c = 0; c < 5; c++) begin
               if (c > 0) @(negedge clk);
               if (mul_ce !== 1'b0 || out_data !== hold || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
            end
            chk("bp_stall", bad, 0);
            tick;
            out_ready = 1'b1;
         end
      join
      wait_drain;
      chk("bp_op_count", op_count, 4);

      // Precision change to INT16 with 2 ops in flight (second is simultaneous)
      do_reset;
      send(tbl[0].a, tbl[0].w, tbl[0].exp);
      in_data = tbl[1].a;
      in_weight = tbl[1].w;
      in_valid = 1'b1;
      cfg_prec = 2'd1;
      cfg_valid = 1'b1;
      @(negedge clk);
      chk("simul_in_ready", in_ready, 1);
      chk("simul_cfg_ready", cfg_ready, 1);
      if (in_ready) sb.push_back(tbl[1].exp);
      tick;
      in_valid = 1'b0;
      cfg_valid = 1'b0;
      rdy_bad = 0; prec_bad = 0; sclr_n = 0; sclr_k = -1; last_k = -1; done_k = -1;
      qsz = -1; prec_at_done = 4'b0000;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (in_ready) rdy_bad++;
         if (mul_sclr) begin
            sclr_n++;
            sclr_k = k;
         end
         if (out_valid && out_ready) last_k = k;
         if (cfg_done) begin
            done_k = k;
            prec_at_done = mul_prec;
            qsz = sb.size();
            break;
         end
         if (mul_prec !== 4'b0001) prec_bad++;
      end
      chk("pc_in_ready_low", rdy_bad, 0);
      chk("pc_prec_held", prec_bad, 0);
      chk("pc_sclr_count", sclr_n, 1);
      chk("pc_last_out", last_k, 3);
      chk("pc_sclr_after_drain", sclr_k, last_k + 2);
      chk("pc_done_cycle", done_k, sclr_k + 1);
      chk("pc_old_delivered", qsz, 0);
      chk("pc_prec_at_done", prec_at_done, 4'b0010);
      tick;
      @(negedge clk);
      chk("pc_in_ready_back", in_ready, 1);
      tick;
      for (int i = 5; i < 8; i++) send(tbl[i].a, tbl[i].w, tbl[i].exp);
      wait_drain;

      // Change back to INT8 with empty pipeline: done 3 cycles after acceptance
      cfg_prec = 2'd0;
      cfg_valid = 1'b1;
      @(negedge clk);
      chk("empty_cfg_ready", cfg_ready, 1);
      tick;
      cfg_valid = 1'b0;
      wait_done(done_k);
      chk("empty_done_cycles", done_k, 3);
      chk("empty_prec", mul_prec, 4'b0001);
      tick;

      // Same-precision request
      cfg_prec = 2'd0;
      cfg_valid = 1'b1;
      @(negedge clk);
      chk("same_done_early", cfg_done, 0);
      tick;
      cfg_valid = 1'b0;
      @(negedge clk);
      chk("same_done", cfg_done, 1);
      chk("same_no_sclr", mul_sclr, 0);
      chk("same_busy", busy, 0);
      tick;
      @(negedge clk);
      chk("same_done_pulse", cfg_done, 0);
      tick;

      // INT64 request
      cfg_prec = 2'd3;
      cfg_valid = 1'b1;
      @(negedge clk);
      tick;
      cfg_valid = 1'b0;
`ifdef SMUL_CHAIN_EN
      wait_done(done_k);
      chk("i64_done", done_k, 3);
      chk("i64_prec", mul_prec, 4'b1000);
      chk("i64_chain", mul_chain, 1);
      chk("i64_no_err", cfg_err, 0);
      tick;
      send(64'h0000_0001_0000_0000, 64'h10, 64'h0000_0010_0000_0000);
      wait_drain;
`else
      @(negedge clk);
      chk("i64_err", cfg_err, 1);
      chk("i64_no_done", cfg_done, 0);
      chk("i64_prec_kept", mul_prec, 4'b0001);
      chk("i64_chain_off", mul_chain, 0);
      tick;
      @(negedge clk);
      chk("i64_err_pulse", cfg_err, 0);
      chk("i64_busy", busy, 0);
      tick;
      send(tbl[3].a, tbl[3].w, tbl[3].exp);
      wait_drain;
`endif

      // Reset mid-DRAIN with 2 tokens in flight
      do_reset;
      send(tbl[1].a, tbl[1].w, tbl[1].exp);
      in_data = tbl[2].a;
      in_weight = tbl[2].w;
      in_valid = 1'b1;
      cfg_prec = 2'd1;
      cfg_valid = 1'b1;
      @(negedge clk);
      if (in_ready) sb.push_back(tbl[2].exp);
      tick;
      in_valid = 1'b0;
      cfg_valid = 1'b0;
      chk("mid_drain_busy", busy, 1);
      chk("mid_drain_in_ready", in_ready, 0);
      rst = 1'b1;
      sb.delete();
      #1;
      chk("mid_rst_prec", mul_prec, 4'b0001);
      chk("mid_rst_run", {in_ready, cfg_ready}, 2'b11);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      tick;
      rst = 1'b0;
      nv = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid) nv++;
      end
      chk("mid_rst_no_valid", nv, 0);
      tick;

      // Counter wrap: 17 products with a 4-bit counter
      do_reset;
      for (int i = 0; i < 17; i++) begin
         ra = {$urandom, $urandom};
         rw = {$urandom, $urandom};
         send(ra, rw, ref_prod(ra, rw, 4'b0001));
      end
      wait_drain;
      chk("wrap_op_count", op_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
